asic_sample_sequencer: RTL and testbench
========================================

Name: asic_sample_sequencer

Overview:
- Batch controller for the ASIC nonlinearity path (DAC write → ASIC → XADC read-back).
- Walks NUM samples from an input sample RAM and issues one conversion per sample to the ASIC function interface.
- Writes each 16-bit XADC result to an output RAM, with a programmable settle gap between conversions.
- Sits between the DFR reservoir control logic and the ASIC function interface; sole owner of that interface's start/data_in.

Parameters:
- ADDR_WIDTH, 15, width of sample index and RAM addresses (max batch 2^ADDR_WIDTH).
- SETTLE_CYCLES, 16, idle clocks after each result write before the next fetch; 0 = no gap.
- TIMEOUT_CYCLES, 4096, watchdog limit per conversion (used only with ASIC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a batch when idle.
- abort  in  1  single-cycle pulse; ends the batch early.
- num_samples  in  ADDR_WIDTH+1  batch length; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at batch end (normal, abort or timeout).
- error  out  1  sticky timeout flag; cleared on next accepted start.
- in_rd_en  out  1  input RAM read strobe.
- in_rd_addr  out  ADDR_WIDTH  input RAM address.
- in_rd_data  in  16  input RAM data, valid exactly 1 clk after in_rd_en.
- out_wr_en  out  1  output RAM write strobe.
- out_wr_addr  out  ADDR_WIDTH  output RAM address.
- out_wr_data  out  16  output RAM data.
- asic_start  out  1  one-cycle start pulse to ASIC interface.
- asic_data_in  out  16  registered DAC code; held stable from start until result.
- asic_ready  in  1  ASIC interface data-valid/idle flag.
- asic_data_out  in  16  XADC result; valid while asic_ready=1.

Behaviour:
- Reset: state IDLE; index=0; all outputs 0, including asic_data_in and error.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_BUSY, WAIT_DONE, SETTLE.
- IDLE:
  - start with num_samples≠0: latch num_samples, index=0, clear error, busy=1, go to FETCH.
  - start with num_samples=0: done pulses on the next clk; no RAM or ASIC activity; busy stays 0.
- FETCH: in_rd_en=1 and in_rd_addr=index for 1 clk; go to LATCH.
- LATCH: asic_data_in<=in_rd_data; go to ISSUE.
- ISSUE:
  - Wait for asic_ready=1.
  - Then asic_start=1 for exactly one clk; go to WAIT_BUSY.
- WAIT_BUSY: wait for asic_ready=0 (acknowledge); go to WAIT_DONE. asic_ready is ignored in the start cycle itself.
- WAIT_DONE:
  - On the first clk with asic_ready=1: out_wr_en=1, out_wr_addr=index, out_wr_data=asic_data_out, all for 1 clk.
  - Then go to SETTLE, or straight to the end check if SETTLE_CYCLES=0.
- SETTLE: count SETTLE_CYCLES clks, then run the end check.
- End check:
  - If index==num_samples−1: done=1 for 1 clk, busy=0, go to IDLE.
  - Otherwise: index+1, go to FETCH.
- Minimum per-sample cost: 4 clks + ASIC conversion time + SETTLE_CYCLES.
- num_samples=2^ADDR_WIDTH is legal; the index never wraps within a batch.
- Other start pulses: ignored while busy=1.
- abort in any non-IDLE state: go to IDLE next clk, pulse done, busy=0. An in-flight ASIC conversion completes unobserved and no write occurs. The next batch's ISSUE waits for asic_ready, so this is safe.
- abort and start in the same cycle while IDLE: start wins.
- Reset mid-batch: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: ASIC_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_DONE and clears on entry to ISSUE.
  - On reaching TIMEOUT_CYCLES: error=1 (sticky), no output write, done pulses, go to IDLE.
- Undefined: no counter; error tied 0; WAIT states wait indefinitely.

Test Plan:
- num_samples=4, input RAM {0x0000,0x4000,0x8000,0xFFFF}, ASIC model echoes code^0x00FF after 20 clks → output RAM {0x00FF,0x40FF,0x80FF,0xFF00}; 4 asic_start pulses; one done; busy low after done.
- SETTLE_CYCLES=16: measure clks from out_wr_en to the next in_rd_en → exactly 17; with SETTLE_CYCLES=0 → exactly 1.
- start with num_samples=0 → done 1 clk later; zero in_rd_en, asic_start and out_wr_en.
- abort asserted in WAIT_DONE of sample 2 of 5 → done next clk; writes only at addr 0,1; new start then completes a clean 5-sample batch.
- ASIC model never raises asic_ready (ASIC_TIMEOUT_EN, TIMEOUT_CYCLES=64) → error=1 and done within 64±1 clks of start; no write; error clears on next start.
- rst asserted mid-WAIT_BUSY → all outputs 0 asynchronously; start after reset release runs a normal batch.

Source files
------------

// File: rtl/asic_sample_sequencer.sv
// asic_sample_sequencer: batch controller for the DAC -> ASIC -> XADC path.
// It walks num_samples codes from the input RAM, issues one ASIC conversion
// per code and stores each 16-bit result at the same index in the output RAM.
// A programmable settle gap follows every result write.
// Optional per-conversion watchdog: define ASIC_TIMEOUT_EN.
module asic_sample_sequencer #(
   parameter int ADDR_WIDTH     = 15,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH:0]   num_samples,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  in_rd_en,
   output logic [ADDR_WIDTH-1:0] in_rd_addr,
   input  logic [15:0]           in_rd_data,
   output logic                  out_wr_en,
   output logic [ADDR_WIDTH-1:0] out_wr_addr,
   output logic [15:0]           out_wr_data,
   output logic                  asic_start,
   output logic [15:0]           asic_data_in,
   input  logic                  asic_ready,
   input  logic [15:0]           asic_data_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_SETTLE
   } state_t;

   // The settle counter also covers the write cycle itself, so it counts
   // 0..SETTLE_CYCLES; the +2 keeps the width non-zero when SETTLE_CYCLES=0.
   localparam int              SW          = $clog2(SETTLE_CYCLES + 2);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   index;
   logic [ADDR_WIDTH-1:0]   last_index;   // num_samples-1, fixed for the batch
   logic [SW-1:0]           settle_cnt;

`ifdef ASIC_TIMEOUT_EN
   localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]            wd_cnt;
`else
   // Without the watchdog the WAIT states block until the ASIC answers.
   assign error = 1'b0;
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // Sequencer FSM: state, index and every output are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         index        <= '0;
         last_index   <= '0;
         settle_cnt   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         in_rd_en     <= 1'b0;
         in_rd_addr   <= '0;
         out_wr_en    <= 1'b0;
         out_wr_addr  <= '0;
         out_wr_data  <= '0;
         asic_start   <= 1'b0;
         asic_data_in <= '0;
`ifdef ASIC_TIMEOUT_EN
         error        <= 1'b0;
         wd_cnt       <= '0;
`endif
      end else begin
         // NOTE: strobes default low here; a later non-blocking assignment in
         // this block overrides it, so each branch only raises what it needs.
         done       <= 1'b0;
         in_rd_en   <= 1'b0;
         out_wr_en  <= 1'b0;
         asic_start <= 1'b0;

         if (abort && state != S_IDLE) begin
            // An in-flight conversion is left to finish unobserved; the next
            // ISSUE waits for asic_ready before starting another one.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
`ifdef ASIC_TIMEOUT_EN
                     error <= 1'b0;
`endif
                     if (num_samples != '0) begin
                        last_index <= ADDR_WIDTH'(num_samples - 1'b1);
                        index      <= '0;
                        busy       <= 1'b1;
                        in_rd_en   <= 1'b1;
                        in_rd_addr <= '0;
                        state      <= S_FETCH;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               S_FETCH: state <= S_LATCH;
               S_LATCH: begin
                  asic_data_in <= in_rd_data;
                  state        <= S_ISSUE;
               end
               S_ISSUE: begin
                  if (asic_ready) begin
                     asic_start <= 1'b1;
                     state      <= S_WAIT_BUSY;
                  end
               end
               S_WAIT_BUSY: begin
                  // asic_start is still high in the start cycle; the ASIC has
                  // not had a chance to drop asic_ready yet, so ignore it.
                  if (!asic_start && !asic_ready) state <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (asic_ready) begin
                     out_wr_en   <= 1'b1;
                     out_wr_addr <= index;
                     out_wr_data <= asic_data_out;
                     settle_cnt  <= '0;
                     state       <= S_SETTLE;
                  end
               end
               S_SETTLE: begin
                  if (settle_cnt == SETTLE_LAST) begin
                     if (index == last_index) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        index      <= index + 1'b1;
                        in_rd_en   <= 1'b1;
                        in_rd_addr <= index + 1'b1;
                        state      <= S_FETCH;
                     end
                  end else begin
                     settle_cnt <= settle_cnt + 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase

`ifdef ASIC_TIMEOUT_EN
            // Watchdog: runs only while a conversion is outstanding.
            if (state == S_LATCH) begin
               wd_cnt <= '0;
            end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
               if (wd_cnt == TIMEOUT_LAST) begin
                  error     <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  out_wr_en <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_asic_sample_sequencer.sv
// Bench for asic_sample_sequencer. Instance 0: 16-entry RAMs, 16-clk settle.
// Instance 1: 8-entry RAMs, no settle gap. Both use a 64-clk watchdog when
// ASIC_TIMEOUT_EN is defined. Each has a RAM pair and an ASIC model that
// answers code^0x00FF after a programmable latency.
module tb_asic_sample_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  start_v = '0, abort_v = '0;
   logic [4:0]  num_v [2];
   logic [1:0]  busy_v, done_v, error_v, rd_en_v, wr_en_v, ast_v, ready_v;
   logic [3:0]  rd_addr_v [2], wr_addr_v [2];
   logic [15:0] rd_data_v [2], wr_data_v [2], din_v [2], dout_v [2];
   logic [2:0]  b_rd_addr, b_wr_addr;

   assign rd_addr_v[1] = {1'b0, b_rd_addr};
   assign wr_addr_v[1] = {1'b0, b_wr_addr};

   asic_sample_sequencer #(.ADDR_WIDTH(4), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
      .num_samples(num_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]),
      .in_rd_en(rd_en_v[0]), .in_rd_addr(rd_addr_v[0]), .in_rd_data(rd_data_v[0]),
      .out_wr_en(wr_en_v[0]), .out_wr_addr(wr_addr_v[0]), .out_wr_data(wr_data_v[0]),
      .asic_start(ast_v[0]), .asic_data_in(din_v[0]),
      .asic_ready(ready_v[0]), .asic_data_out(dout_v[0]));

   asic_sample_sequencer #(.ADDR_WIDTH(3), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
      .num_samples(num_v[1][3:0]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]),
      .in_rd_en(rd_en_v[1]), .in_rd_addr(b_rd_addr), .in_rd_data(rd_data_v[1]),
      .out_wr_en(wr_en_v[1]), .out_wr_addr(b_wr_addr), .out_wr_data(wr_data_v[1]),
      .asic_start(ast_v[1]), .asic_data_in(din_v[1]),
      .asic_ready(ready_v[1]), .asic_data_out(dout_v[1]));

   // Stimulus-owned model settings
   logic [15:0] in_ram [2][16];
   int lat [2], ack [2], hang [2], batch_id [2];
   int rd0 [2], st0 [2], wr0 [2], dn0 [2];
   int n_checks = 0, n_pass = 0;

   // ASIC model and input RAM (registered read, data one clk after the strobe)
   int          phase [2], mcnt [2];
   logic [15:0] code [2];
   int          stab_err [2] = '{0, 0};
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            phase[i] <= 0; mcnt[i] <= 0; code[i] <= '0;
            ready_v[i] <= 1'b1; dout_v[i] <= '0; rd_data_v[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (rd_en_v[i]) rd_data_v[i] <= in_ram[i][rd_addr_v[i]];
            if (phase[i] != 0 && din_v[i] !== code[i]) stab_err[i] <= stab_err[i] + 1;
            case (phase[i])
               0: if (ast_v[i]) begin
                     code[i] <= din_v[i];
                     if (ack[i] == 0) begin
                        ready_v[i] <= 1'b0; dout_v[i] <= 16'($urandom);
                        phase[i] <= 2; mcnt[i] <= lat[i];
                     end else begin
                        phase[i] <= 1; mcnt[i] <= ack[i];
                     end
                  end
               1: if (mcnt[i] <= 1) begin
                     ready_v[i] <= 1'b0; dout_v[i] <= 16'($urandom);
                     phase[i] <= 2; mcnt[i] <= lat[i];
                  end else mcnt[i] <= mcnt[i] - 1;
               default: if (hang[i] == 0) begin
                     if (mcnt[i] == 0) begin
                        ready_v[i] <= 1'b1; dout_v[i] <= code[i] ^ 16'h00FF; phase[i] <= 0;
                     end else mcnt[i] <= mcnt[i] - 1;
                  end
            endcase
         end
      end
   end

   // Event monitor: counts strobes, records the output RAM and timing gaps
   int          cyc = 0;
   int          rd_n [2] = '{0, 0}, st_n [2] = '{0, 0}, wr_n [2] = '{0, 0}, done_n [2] = '{0, 0};
   int          last_st [2], done_cyc [2], last_wr [2] = '{-1, -1}, seen_b [2] = '{0, 0};
   int          gap_min [2], gap_max [2];
   logic [15:0] out_ram [2][16];
   int          wr_tag [2][16];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (batch_id[i] != seen_b[i]) begin
            seen_b[i] <= batch_id[i]; last_wr[i] <= -1; gap_min[i] <= 1000000; gap_max[i] <= 0;
         end else if (rd_en_v[i] && last_wr[i] >= 0) begin
            gap_min[i] <= (cyc - last_wr[i] < gap_min[i]) ? cyc - last_wr[i] : gap_min[i];
            gap_max[i] <= (cyc - last_wr[i] > gap_max[i]) ? cyc - last_wr[i] : gap_max[i];
         end
         if (rd_en_v[i]) rd_n[i] <= rd_n[i] + 1;
         if (ast_v[i]) begin st_n[i] <= st_n[i] + 1; last_st[i] <= cyc; end
         if (done_v[i]) begin done_n[i] <= done_n[i] + 1; done_cyc[i] <= cyc; end
         if (wr_en_v[i]) begin
            wr_n[i] <= wr_n[i] + 1; last_wr[i] <= cyc;
            out_ram[i][wr_addr_v[i]] <= wr_data_v[i];
            wr_tag[i][wr_addr_v[i]]  <= batch_id[i];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int ram_size(input int i);
      return (i == 0) ? 16 : 8;
   endfunction

   // Reference: in this batch exactly entries 0..n-1 hold in_ram ^ 0x00FF.
   function automatic int count_bad(input int i, input int n);
      int bad = 0;
      for (int a = 0; a < ram_size(i); a++) begin
         if ((wr_tag[i][a] == batch_id[i]) != (a < n)) bad++;
         else if (a < n && out_ram[i][a] !== (in_ram[i][a] ^ 16'h00FF)) bad++;
      end
      return bad;
   endfunction

   task automatic begin_batch(input int i, input int n);
      @(negedge clk);
      batch_id[i]++;
      rd0[i] = rd_n[i]; st0[i] = st_n[i]; wr0[i] = wr_n[i]; dn0[i] = done_n[i];
      num_v[i] = 5'(n); start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget, input string tag);
      int k = 0;
      while (done_v[i] !== 1'b1 && k < budget) begin @(negedge clk); k++; end
      check({tag, " done"}, done_v[i], 1'b1);
      check({tag, " busy at done"}, busy_v[i], 1'b0);
   endtask

   task automatic wait_ready(input int i, input string tag);
      int k = 0;
      while (ready_v[i] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      check({tag, " asic idle"}, ready_v[i], 1'b1);
   endtask

   task automatic verify_batch(input int i, input int n, input string tag);
      repeat (4) @(negedge clk);
      check({tag, " done count"}, 64'(done_n[i] - dn0[i]), 64'd1);
      check({tag, " rd count"},   64'(rd_n[i] - rd0[i]),   64'(n));
      check({tag, " start count"}, 64'(st_n[i] - st0[i]),  64'(n));
      check({tag, " wr count"},   64'(wr_n[i] - wr0[i]),   64'(n));
      check({tag, " out ram bad"}, 64'(count_bad(i, n)),   64'd0);
      check({tag, " error"},      error_v[i], 1'b0);
      if (n > 1) begin
         check({tag, " gap min"}, 64'(gap_min[i]), 64'((i == 0) ? 17 : 1));
         check({tag, " gap max"}, 64'(gap_max[i]), 64'((i == 0) ? 17 : 1));
      end
   endtask

   task automatic run_batch(input int i, input int n, input string tag);
      begin_batch(i, n);
      wait_done(i, n * (lat[i] + ack[i] + ((i == 0) ? 16 : 0) + 12) + 40, tag);
      verify_batch(i, n, tag);
   endtask

   function automatic logic [63:0] outs(input int i);
      return {18'd0, busy_v[i], done_v[i], error_v[i], rd_en_v[i], rd_addr_v[i],
              wr_en_v[i], wr_addr_v[i], wr_data_v[i], ast_v[i], din_v[i]};
   endfunction

   initial begin
      int k;
      for (int i = 0; i < 2; i++) begin
         num_v[i] = '0; lat[i] = 20; ack[i] = 0; hang[i] = 0; batch_id[i] = 0;
         for (int a = 0; a < 16; a++) begin in_ram[i][a] = 16'($urandom); wr_tag[i][a] = -1; end
      end
      repeat (3) @(negedge clk);
      check("reset outs a", outs(0), 64'd0);
      check("reset outs b", outs(1), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed four-sample batch with the reference code set
      in_ram[0][0] = 16'h0000; in_ram[0][1] = 16'h4000;
      in_ram[0][2] = 16'h8000; in_ram[0][3] = 16'hFFFF;
      run_batch(0, 4, "dir4");
      check("dir4 word3", out_ram[0][3], 16'hFF00);
      run_batch(1, 3, "settle0");

      // Zero-length batch: done one clock after start, nothing else
      begin_batch(0, 0);
      check("zero done", done_v[0], 1'b1);
      check("zero busy", busy_v[0], 1'b0);
      repeat (5) @(negedge clk);
      check("zero rd", 64'(rd_n[0] - rd0[0]), 64'd0);
      check("zero start", 64'(st_n[0] - st0[0]), 64'd0);
      check("zero wr", 64'(wr_n[0] - wr0[0]), 64'd0);
      check("zero done count", 64'(done_n[0] - dn0[0]), 64'd1);

      // Abort while sample 2 of 5 is converting
      begin_batch(0, 5);
      k = 0;
      while (st_n[0] - st0[0] < 3 && k < 500) begin @(negedge clk); k++; end
      check("abort third start", 64'(st_n[0] - st0[0]), 64'd3);
      repeat (3) @(negedge clk);
      abort_v[0] = 1'b1;
      @(negedge clk);
      abort_v[0] = 1'b0;
      check("abort done", done_v[0], 1'b1);
      check("abort busy", busy_v[0], 1'b0);
      repeat (3) @(negedge clk);
      check("abort wr count", 64'(wr_n[0] - wr0[0]), 64'd2);
      check("abort out ram bad", 64'(count_bad(0, 2)), 64'd0);
      wait_ready(0, "abort");
      run_batch(0, 5, "post abort");

      // Abort and start together while idle: start wins
      @(negedge clk);
      abort_v[1] = 1'b1;
      begin_batch(1, 2);
      abort_v[1] = 1'b0;
      check("start wins busy", busy_v[1], 1'b1);
      wait_done(1, 200, "start wins");
      verify_batch(1, 2, "start wins");

`ifdef ASIC_TIMEOUT_EN
      // Watchdog: the ASIC acknowledges but never returns a result
      hang[0] = 1;
      begin_batch(0, 2);
      wait_done(0, 300, "timeout");
      check("timeout error", error_v[0], 1'b1);
      check("timeout latency ok", 64'((done_cyc[0] - last_st[0] >= 63) && (done_cyc[0] - last_st[0] <= 65)), 64'd1);
      check("timeout wr count", 64'(wr_n[0] - wr0[0]), 64'd0);
      hang[0] = 0;
      wait_ready(0, "timeout");
      begin_batch(0, 1);
      check("error cleared", error_v[0], 1'b0);
      wait_done(0, 200, "post timeout");
      verify_batch(0, 1, "post timeout");
`endif

      // Reset in WAIT_BUSY (ASIC slow to acknowledge)
      ack[0] = 5;
      for (int a = 0; a < 16; a++) in_ram[0][a] = 16'($urandom_range(1, 65535));
      begin_batch(0, 3);
      k = 0;
      while (st_n[0] == st0[0] && k < 200) begin @(negedge clk); k++; end
      check("rst busy before", busy_v[0], 1'b1);
      rst = 1'b1;
      #1;
      check("rst async outs", outs(0), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst no done", 64'(done_n[0] - dn0[0]), 64'd0);
      @(negedge clk);
      run_batch(0, 3, "post rst");

      // Randomized batches, including full-depth ones
      for (int r = 0; r < 6; r++) begin
         int i, n;
         i = r % 2;
         n = (r < 2) ? ram_size(i) : int'($urandom_range(1, ram_size(i)));
         lat[i] = int'($urandom_range(0, 8));
         ack[i] = int'($urandom_range(0, 2));
         for (int a = 0; a < 16; a++) in_ram[i][a] = 16'($urandom);
         run_batch(i, n, $sformatf("rand%0d", r));
      end

      check("data_in stable a", 64'(stab_err[0]), 64'd0);
      check("data_in stable b", 64'(stab_err[1]), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
